// File: rtl/circuito_pkg.sv
// Shared constants and helpers for the distance-gated LED blinker.
package circuito_pkg;

  localparam int CLK_HZ_PADRAO   = 100;
  localparam int TOGGLE_S_PADRAO = 5;
  localparam int LIM_MIN_PADRAO  = 2;
  localparam int LIM_MAX_PADRAO  = 30;

  // Counter width able to hold 0 .. ticks-1, never narrower than one bit.
  function automatic int largura_contador(input int ticks);
    return (ticks <= 2) ? 1 : $clog2(ticks);
  endfunction

endpackage

// File: rtl/divisor_frequencia.sv
// Clock divider: counts while enabled and emits a one-cycle tick every
// TICKS cycles. Dropping the enable clears the count so the phase restarts.
module divisor_frequencia
  import circuito_pkg::*;
#(
  parameter int TICKS = CLK_HZ_PADRAO * TOGGLE_S_PADRAO
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int             W      = largura_contador(TICKS);
  localparam logic [W-1:0]   ULTIMO = W'(TICKS - 1);

  if (TICKS < 2) begin : g_ticks_invalido
    $error("divisor_frequencia: TICKS must be at least 2");
  end

  logic [W-1:0] contador;

  // The tick is decoded from the registered count, so it is glitch-free and
  // lands on the cycle the counter wraps.
  assign tick = en && (contador == ULTIMO);

  // Count while enabled, wrap on the last value, clear when disabled.
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    if (!rst_n) begin
      contador <= '0;
    end else if (!en) begin
      contador <= '0;
    end else if (tick) begin
      contador <= '0;
    end else begin
      contador <= contador + 1'b1;
    end
  end

endmodule

// File: rtl/circuito_pisca_led.sv
// Distance-gated LED blinker: while the distance reading sits inside the
// window, the LED toggles every TOGGLE_S seconds; outside it the LED is off.
module circuito_pisca_led
  import circuito_pkg::*;
#(
  parameter int CLK_HZ   = CLK_HZ_PADRAO,
  parameter int TOGGLE_S = TOGGLE_S_PADRAO,
  parameter int LIM_MIN  = LIM_MIN_PADRAO,
  parameter int LIM_MAX  = LIM_MAX_PADRAO
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] distancia_cm,
  output logic       led,
  output logic       dentro_limite
);

  localparam int         TICKS     = CLK_HZ * TOGGLE_S;
  localparam logic [7:0] LIM_MIN_8 = 8'(LIM_MIN);
  localparam logic [7:0] LIM_MAX_8 = 8'(LIM_MAX);

  if (LIM_MIN > LIM_MAX) begin : g_janela_invalida
    $error("circuito_pisca_led: LIM_MIN must not exceed LIM_MAX");
  end
  if (LIM_MIN < 0 || LIM_MAX > 255) begin : g_janela_fora_8bit
    $error("circuito_pisca_led: window limits must fit in 8 bits");
  end

  logic na_janela;
  logic tick;

  // Unsigned 8-bit window compare; 0 and 255 are simply out of range.
  assign na_janela = (distancia_cm >= LIM_MIN_8) && (distancia_cm <= LIM_MAX_8);

  // Register the in-range flag; it also gates the divider.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dentro_limite <= 1'b0;
    end else begin
      dentro_limite <= na_janela;
    end
  end

  divisor_frequencia #(
    .TICKS (TICKS)
  ) u_divisor (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (dentro_limite),
    .tick  (tick)
  );

  // LED toggles on each tick; leaving the window forces it off, and that
  // clear takes priority over a coincident tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led <= 1'b0;
    end else if (!dentro_limite) begin
      led <= 1'b0;
    end else if (tick) begin
      led <= ~led;
    end
  end

endmodule

// File: tb/tb_circuito_pisca_led.sv
// Self-checking bench for circuito_pisca_led with default parameters.
module tb_circuito_pisca_led;

  localparam int TICKS = 500;
  localparam int LMIN  = 2;
  localparam int LMAX  = 30;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] distancia_cm;
  logic       led;
  logic       dentro_limite;

  circuito_pisca_led dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .distancia_cm  (distancia_cm),
    .led           (led),
    .dentro_limite (dentro_limite)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   m_dl     = 1'b0;  // model: registered in-range flag
  int   m_n      = 0;     // model: edges counted since the flag went high
  logic prev_led = 1'b0;
  int   toggles[$];       // cycle numbers where led changed

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit in_window(input int d);
    return (d >= LMIN) && (d <= LMAX);
  endfunction

  // One clock: update the behavioural model at the rising edge, compare
  // on the falling edge, and log LED transitions.
  task automatic step();
    int exp_led;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      m_dl = 1'b0;
      m_n  = 0;
    end else begin
      m_n  = m_dl ? m_n + 1 : 0;
      m_dl = in_window(int'(distancia_cm));
    end
    exp_led = (m_n / TICKS) % 2;
    @(negedge clk);
    check("dentro_limite", 32'(dentro_limite), 32'(m_dl));
    check("led", 32'(led), 32'(exp_led));
    if (led !== prev_led) toggles.push_back(cyc);
    prev_led = led;
  endtask

  function automatic int toggle_delta(input int idx, input int base);
    return (idx < toggles.size()) ? toggles[idx] - base : -1;
  endfunction

  initial begin
    int e_cyc;
    int guard;
    bit seen_high;
    int bd[5];
    bit be[5];
    bd = '{1, 2, 30, 29, 31};
    be = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    // 1: reset held with an in-range distance
    rst_n        = 1'b0;
    distancia_cm = 8'd20;
    repeat (3) begin
      step();
      check("s1_rst_led", 32'(led), 32'd0);
      check("s1_rst_dl", 32'(dentro_limite), 32'd0);
    end
    rst_n = 1'b1;
    step();
    check("s1_dl_release", 32'(dentro_limite), 32'd1);
    e_cyc = cyc;
    toggles.delete();

    // 2: steady in-range reading for 15 s
    repeat (1500) step();
    check("s2_ntoggles", 32'(toggles.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      check("s2_toggle_time", 32'(toggle_delta(i, e_cyc)), 32'(TICKS * (i + 1)));
    check("s2_led_end", 32'(led), 32'd1);

    // 3: window boundaries
    for (int i = 0; i < 5; i++) begin
      distancia_cm = 8'(bd[i]);
      step();
      step();
      check("s3_boundary", 32'(dentro_limite), 32'(be[i]));
    end

    // 4: leave the window while the LED is on, then come back
    distancia_cm = 8'd20;
    guard = 0;
    while (led !== 1'b1 && guard < 1200) begin
      step();
      guard++;
    end
    check("s4_led_high", 32'(led), 32'd1);
    distancia_cm = 8'd50;
    step();
    check("s4_dl_drop", 32'(dentro_limite), 32'd0);
    check("s4_led_hold", 32'(led), 32'd1);
    step();
    check("s4_led_clear", 32'(led), 32'd0);
    distancia_cm = 8'd20;
    step();
    check("s4_dl_back", 32'(dentro_limite), 32'd1);
    e_cyc = cyc;
    toggles.delete();
    guard = 0;
    while (led !== 1'b1 && guard < 600) begin
      step();
      guard++;
    end
    check("s4_rise_delay", 32'(toggle_delta(0, e_cyc)), 32'(TICKS));

    // 5: one-cycle reset mid-blink clears the phase
    repeat (200) step();
    rst_n = 1'b0;
    step();
    check("s5_rst_led", 32'(led), 32'd0);
    check("s5_rst_dl", 32'(dentro_limite), 32'd0);
    rst_n = 1'b1;
    step();
    check("s5_dl_release", 32'(dentro_limite), 32'd1);
    e_cyc = cyc;
    toggles.delete();
    repeat (TICKS) step();
    check("s5_ntoggles", 32'(toggles.size()), 32'd1);
    check("s5_rise_delay", 32'(toggle_delta(0, e_cyc)), 32'(TICKS));

    // 6: extreme out-of-range readings keep everything off
    distancia_cm = 8'd0;
    repeat (2) step();
    seen_high = 1'b0;
    repeat (600) begin
      step();
      if (led !== 1'b0 || dentro_limite !== 1'b0) seen_high = 1'b1;
    end
    distancia_cm = 8'd255;
    repeat (600) begin
      step();
      if (led !== 1'b0 || dentro_limite !== 1'b0) seen_high = 1'b1;
    end
    check("s6_quiet", 32'(seen_high), 32'd0);

    // Random segments, biased toward the window edges, with occasional resets
    for (int s = 0; s < 40; s++) begin
      int r;
      int len;
      r = int'($urandom_range(0, 9));
      distancia_cm = (r < 6) ? 8'($urandom_range(0, 34)) : 8'($urandom_range(0, 255));
      len = int'($urandom_range(1, (r < 3) ? 3 : 700));
      if ($urandom_range(0, 9) == 0) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
      repeat (len) step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
